// File: rtl/memory_access_stage_pkg.sv
// rtl/memory_access_stage_pkg.sv - shared types and lane helpers for the MEM pipeline stage
package memory_access_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } memState_;

  typedef enum logic [1:0] {
    WIDTH_B = 2'd0,
    WIDTH_H = 2'd1,
    WIDTH_W = 2'd2
  } memoryWidth_;

  typedef struct packed {
    logic stall;
    logic flush;
  } pipelineControl_;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        regWrite;
    logic        memoryReadEnable;
    logic        memoryWriteEnable;
    memoryWidth_ memoryWidth;
    logic        memorySigned;
    logic [31:0] result;     // effective address for memory ops
    logic [31:0] storeData;
  } executeMemoryPayload_;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        regWrite;
    logic [31:0] result;
    logic        accessFault;
    logic        misaligned;
  } memoryWritebackPayload_;

  // Byte offset rounded down to the access's natural boundary.
  function automatic logic [1:0] natural_offset(memoryWidth_ w, logic [1:0] off);
    case (w)
      WIDTH_B: return off;
      WIDTH_H: return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(memoryWidth_ w, logic [1:0] off);
    return natural_offset(w, off) != off;
  endfunction

endpackage

// File: rtl/memory_access_stage_if.sv
// rtl/memory_access_stage_if.sv - req/ack data-memory bus between the MEM stage and memory
interface memory_access_stage_if;
  logic        dmemReq;
  logic        dmemWriteEnable;
  logic [31:0] dmemAddress;
  logic [31:0] dmemWriteData;
  logic [3:0]  dmemByteEnable;
  logic        dmemAck;
  logic [31:0] dmemReadData;

  modport master (
    output dmemReq, dmemWriteEnable, dmemAddress, dmemWriteData, dmemByteEnable,
    input  dmemAck, dmemReadData
  );

  modport slave (
    input  dmemReq, dmemWriteEnable, dmemAddress, dmemWriteData, dmemByteEnable,
    output dmemAck, dmemReadData
  );
endinterface

// File: rtl/memory_access_stage_load_align.sv
// rtl/memory_access_stage_load_align.sv - selects the loaded byte/half and extends it to 32 bits
module memory_access_stage_load_align
  import memory_access_stage_pkg::*;
(
  input  logic [31:0] raw_i,
  input  memoryWidth_ width_i,
  input  logic        signed_i,
  input  logic [1:0]  offset_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane(s) and sign- or zero-extend; words pass through.
  always_comb begin
    byte_sel = raw_i[{offset_i, 3'b000} +: 8];
    half_sel = offset_i[1] ? raw_i[31:16] : raw_i[15:0];
    case (width_i)
      WIDTH_B: data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      WIDTH_H: data_o = {{16{signed_i & half_sel[15]}}, half_sel};
      default: data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// rtl/memory_access_stage.sv - MEM stage: dmem req/ack access FSM, lanes, timeout; MEM_MISALIGN_TRAP_EN enables misalign trap
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  executeMemoryPayload_   executeMemoryPayload,
  input  pipelineControl_        memoryWritebackControl,
  output memoryWritebackPayload_ memoryWritebackPayload,
  output logic                   memoryStall,
  output logic [31:0]            forwardData,
  memory_access_stage_if.master  dmem
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

  memState_               state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   req_q, req_d;
  logic                   we_q, we_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [3:0]             be_q, be_d;
  logic [31:0]            result_q, result_d;
  logic                   fault_q, fault_d;
  logic                   mis_q, mis_d;
  logic                   flush_pend_q, flush_pend_d;
  memoryWidth_            width_q, width_d;
  logic                   signed_q, signed_d;
  logic [1:0]             off_q, off_d;
  logic                   read_q, read_d;
  memoryWritebackPayload_ wb_q, wb_d;

  logic        mem_op;
  logic        misaligned_now;
  logic [1:0]  off_eff;
  logic [3:0]  lanes;
  logic [31:0] lane_data;
  logic [31:0] load_data;

  memory_access_stage_load_align u_load_align (
    .raw_i    (dmem.dmemReadData),
    .width_i  (width_q),
    .signed_i (signed_q),
    .offset_i (off_q),
    .data_o   (load_data)
  );

  // Decode the incoming op: effective offset, misalignment and store lanes.
  always_comb begin
    mem_op  = executeMemoryPayload.valid &
              (executeMemoryPayload.memoryReadEnable | executeMemoryPayload.memoryWriteEnable);
    off_eff = natural_offset(executeMemoryPayload.memoryWidth, executeMemoryPayload.result[1:0]);
`ifdef MEM_MISALIGN_TRAP_EN
    misaligned_now = is_misaligned(executeMemoryPayload.memoryWidth, executeMemoryPayload.result[1:0]);
`else
    misaligned_now = 1'b0;
`endif
    case (executeMemoryPayload.memoryWidth)
      WIDTH_B: begin
        lanes     = 4'b0001 << off_eff;
        lane_data = {4{executeMemoryPayload.storeData[7:0]}};
      end
      WIDTH_H: begin
        lanes     = 4'b0011 << off_eff;
        lane_data = {2{executeMemoryPayload.storeData[15:0]}};
      end
      default: begin
        lanes     = 4'b1111;
        lane_data = executeMemoryPayload.storeData;
      end
    endcase
  end

  // Access FSM next state, bus latches and MEM->WB register next value.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    result_d     = result_q;
    fault_d      = fault_q;
    mis_d        = mis_q;
    flush_pend_d = flush_pend_q;
    width_d      = width_q;
    signed_d     = signed_q;
    off_d        = off_q;
    read_d       = read_q;
    wb_d         = wb_q;
    case (state_q)
      IDLE: begin
        if (memoryWritebackControl.flush) begin
          wb_d.valid = 1'b0;
        end else if (mem_op) begin
          fault_d = 1'b0;
          if (misaligned_now) begin
            state_d  = RESP;
            mis_d    = 1'b1;
            result_d = executeMemoryPayload.result;
          end else begin
            state_d  = REQ;
            req_d    = 1'b1;
            mis_d    = 1'b0;
            count_d  = '0;
            we_d     = executeMemoryPayload.memoryWriteEnable;
            addr_d   = {executeMemoryPayload.result[31:2], 2'b00};
            wdata_d  = lane_data;
            be_d     = lanes;
            width_d  = executeMemoryPayload.memoryWidth;
            signed_d = executeMemoryPayload.memorySigned;
            off_d    = off_eff;
            read_d   = executeMemoryPayload.memoryReadEnable;
          end
          // Bubble into WB while this access is in flight.
          if (!memoryWritebackControl.stall) wb_d.valid = 1'b0;
        end else if (!memoryWritebackControl.stall) begin
          wb_d.valid       = executeMemoryPayload.valid;
          wb_d.rd          = executeMemoryPayload.rd;
          wb_d.regWrite    = executeMemoryPayload.regWrite;
          wb_d.result      = executeMemoryPayload.result;
          wb_d.accessFault = 1'b0;
          wb_d.misaligned  = 1'b0;
        end
      end
      REQ: begin
        // A flush cannot retract the request; remember it and discard on completion.
        if (memoryWritebackControl.flush) flush_pend_d = 1'b1;
        if (memoryWritebackControl.flush || !memoryWritebackControl.stall) wb_d.valid = 1'b0;
        if (dmem.dmemAck) begin
          state_d  = RESP;
          req_d    = 1'b0;
          result_d = read_q ? load_data : executeMemoryPayload.result;
        end else if (count_q == LAST_COUNT) begin
          state_d  = RESP;
          req_d    = 1'b0;
          fault_d  = 1'b1;
          result_d = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      RESP: begin
        if (memoryWritebackControl.flush || flush_pend_q) begin
          wb_d.valid   = 1'b0;
          flush_pend_d = 1'b0;
          state_d      = IDLE;
        end else if (!memoryWritebackControl.stall) begin
          wb_d.valid       = 1'b1;
          wb_d.rd          = executeMemoryPayload.rd;
          wb_d.regWrite    = executeMemoryPayload.regWrite;
          wb_d.result      = result_q;
          wb_d.accessFault = fault_q;
          wb_d.misaligned  = mis_q;
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops dmemReq immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      result_q     <= '0;
      fault_q      <= 1'b0;
      mis_q        <= 1'b0;
      flush_pend_q <= 1'b0;
      width_q      <= WIDTH_B;
      signed_q     <= 1'b0;
      off_q        <= 2'b00;
      read_q       <= 1'b0;
      wb_q         <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      result_q     <= result_d;
      fault_q      <= fault_d;
      mis_q        <= mis_d;
      flush_pend_q <= flush_pend_d;
      width_q      <= width_d;
      signed_q     <= signed_d;
      off_q        <= off_d;
      read_q       <= read_d;
      wb_q         <= wb_d;
    end
  end

  assign memoryStall            = reset & mem_op & (state_q != RESP);
  assign forwardData            = (state_q == RESP) ? result_q : executeMemoryPayload.result;
  assign memoryWritebackPayload = wb_q;
  assign dmem.dmemReq           = req_q;
  assign dmem.dmemWriteEnable   = we_q;
  assign dmem.dmemAddress       = addr_q;
  assign dmem.dmemWriteData     = wdata_q;
  assign dmem.dmemByteEnable    = be_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// tb/tb_memory_access_stage.sv - self-checking bench for memory_access_stage
module tb_memory_access_stage;
  import memory_access_stage_pkg::*;

  localparam int TO = 4;

  logic                   clock = 1'b0;
  logic                   reset = 1'b0;
  executeMemoryPayload_   ex;
  pipelineControl_        ctrl;
  memoryWritebackPayload_ wb_out;
  logic                   stall;
  logic [31:0]            fwd;

  memory_access_stage_if dmem();

  memory_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .executeMemoryPayload   (ex),
    .memoryWritebackControl (ctrl),
    .memoryWritebackPayload (wb_out),
    .memoryStall            (stall),
    .forwardData            (fwd),
    .dmem                   (dmem)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic executeMemoryPayload_ mk(input logic r, input logic w, input memoryWidth_ wd,
                                              input logic sg, input logic [31:0] a, input logic [31:0] sd);
    executeMemoryPayload_ p;
    p = '0;
    p.valid = 1'b1;
    p.rd = 5'd3;
    p.regWrite = r;
    p.memoryReadEnable = r;
    p.memoryWriteEnable = w;
    p.memoryWidth = wd;
    p.memorySigned = sg;
    p.result = a;
    p.storeData = sd;
    return p;
  endfunction

  // Reference model: what one op should look like on the bus and at WB.
  typedef struct {
    logic [31:0] addr, wdata, result;
    logic [3:0]  be;
    bit          we, issue, fault, mis;
    int          reqs, stalls;
  } exp_t;

  function automatic exp_t model(input executeMemoryPayload_ p, input logic [31:0] rdata, input int ack_at);
    exp_t e;
    int size, off;
    logic [31:0] v, mask;
    e = '{addr: 0, wdata: 0, result: p.result, be: 0, we: 0, issue: 0, fault: 0, mis: 0, reqs: 0, stalls: 0};
    if (!(p.valid && (p.memoryReadEnable || p.memoryWriteEnable))) return e;
    size = (p.memoryWidth == WIDTH_B) ? 1 : (p.memoryWidth == WIDTH_H) ? 2 : 4;
    off = int'(p.result[1:0]);
    if (off % size != 0) begin
`ifdef MEM_MISALIGN_TRAP_EN
      e.mis = 1;
      e.stalls = 1;
      return e;
`else
      off = off - off % size;
`endif
    end
    e.issue = 1;
    e.addr = p.result & ~32'd3;
    e.we = p.memoryWriteEnable;
    e.be = 4'(((1 << size) - 1) << off);
    for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = p.storeData[8*(i % size) +: 8];
    e.reqs = (ack_at >= 1 && ack_at <= TO) ? ack_at : TO;
    e.stalls = e.reqs + 1;
    if (ack_at < 1 || ack_at > TO) begin
      e.fault = 1;
      e.result = 0;
      return e;
    end
    if (p.memoryReadEnable) begin
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      v = (rdata >> (8 * off)) & mask;
      if (p.memorySigned && size < 4 && v[8*size-1]) v = v | ~mask;
      e.result = v;
    end
    return e;
  endfunction

  int                     r_stalls, r_reqs;
  bit                     r_done;
  logic [31:0]            r_addr, r_wdata, r_fwd;
  logic [3:0]             r_be;
  logic                   r_we;
  memoryWritebackPayload_ r_wb;

  // Present one op, play memory (ack on REQ cycle ack_at, 0 = never), optionally flush on REQ cycle flush_at.
  task automatic run_op(input executeMemoryPayload_ p, input logic [31:0] rdata, input int ack_at, input int flush_at);
    ex = p;
    r_stalls = 0; r_reqs = 0; r_done = 0;
    r_addr = '0; r_wdata = '0; r_be = '0; r_we = 1'b0; r_fwd = '0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (stall) r_stalls++;
      if (dmem.dmemReq) begin
        r_reqs++;
        if (r_reqs == 1) begin
          r_addr = dmem.dmemAddress; r_wdata = dmem.dmemWriteData;
          r_be = dmem.dmemByteEnable; r_we = dmem.dmemWriteEnable;
        end
        if (r_reqs == ack_at) begin dmem.dmemAck = 1'b1; dmem.dmemReadData = rdata; end
        if (r_reqs == flush_at) ctrl.flush = 1'b1;
      end
      if (!stall) begin r_fwd = fwd; r_done = 1; end
      @(negedge clock);
      dmem.dmemAck = 1'b0;
      dmem.dmemReadData = $urandom;
      ctrl.flush = 1'b0;
      if (r_done) break;
    end
    check("op_completes_within_budget", 32'(r_done), 32'd1);
    #1;
    r_wb = wb_out;
    ex = '0;
  endtask

  typedef struct {
    logic        rd, wr;
    memoryWidth_ w;
    logic        sg;
    logic [31:0] addr, sdata, rdata;
    int          ack_at;
    logic [3:0]  be;
    logic [31:0] wdata, result;
    int          stalls;
  } vec_t;

  vec_t                 vecs[10];
  vec_t                 v;
  executeMemoryPayload_ p;
  exp_t                 e;
  logic [31:0]          rd_word;
  int                   kind, ack;

  initial begin
    vecs[0] = '{1'b1, 1'b0, WIDTH_W, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 3, 4'hF, 32'h0,        32'hDEADBEEF, 4};
    vecs[1] = '{1'b1, 1'b0, WIDTH_B, 1'b1, 32'h103, 32'h0,        32'h80123456, 1, 4'h8, 32'h0,        32'hFFFFFF80, 2};
    vecs[2] = '{1'b1, 1'b0, WIDTH_B, 1'b0, 32'h103, 32'h0,        32'h80123456, 1, 4'h8, 32'h0,        32'h00000080, 2};
    vecs[3] = '{1'b1, 1'b0, WIDTH_H, 1'b1, 32'h102, 32'h0,        32'h80123456, 2, 4'hC, 32'h0,        32'hFFFF8012, 3};
    vecs[4] = '{1'b1, 1'b0, WIDTH_H, 1'b0, 32'h102, 32'h0,        32'h80123456, 1, 4'hC, 32'h0,        32'h00008012, 2};
    vecs[5] = '{1'b0, 1'b1, WIDTH_B, 1'b0, 32'h201, 32'h000000AB, 32'h0,        1, 4'h2, 32'hABABABAB, 32'h00000201, 2};
    vecs[6] = '{1'b0, 1'b1, WIDTH_H, 1'b0, 32'h202, 32'hCAFE1234, 32'h0,        1, 4'hC, 32'h12341234, 32'h00000202, 2};
    vecs[7] = '{1'b0, 1'b1, WIDTH_W, 1'b0, 32'h300, 32'hCAFEF00D, 32'h0,        2, 4'hF, 32'hCAFEF00D, 32'h00000300, 3};
    vecs[8] = '{1'b1, 1'b0, WIDTH_B, 1'b1, 32'h100, 32'h0,        32'h000000FE, 1, 4'h1, 32'h0,        32'hFFFFFFFE, 2};
    vecs[9] = '{1'b0, 1'b0, WIDTH_W, 1'b0, 32'h55,  32'h0,        32'h0,        0, 4'h0, 32'h0,        32'h00000055, 0};

    ex = '0; ctrl = '0; dmem.dmemAck = 1'b0; dmem.dmemReadData = '0;

    // Reset state
    repeat (2) @(negedge clock);
    #1;
    check("reset_dmemReq", 32'(dmem.dmemReq), 32'd0);
    check("reset_byteEnable", 32'(dmem.dmemByteEnable), 32'd0);
    check("reset_address", dmem.dmemAddress, 32'd0);
    check("reset_wb_valid", 32'(wb_out.valid), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      run_op(mk(v.rd, v.wr, v.w, v.sg, v.addr, v.sdata), v.rdata, v.ack_at, 0);
      check($sformatf("vec%0d_stalls", i), 32'(r_stalls), 32'(v.stalls));
      check($sformatf("vec%0d_result", i), r_wb.result, v.result);
      check($sformatf("vec%0d_valid", i), 32'(r_wb.valid), 32'd1);
      if (v.rd || v.wr) begin
        check($sformatf("vec%0d_be", i), 32'(r_be), 32'(v.be));
        check($sformatf("vec%0d_addr", i), r_addr, v.addr & ~32'd3);
        check($sformatf("vec%0d_we", i), 32'(r_we), 32'(v.wr));
        if (v.wr) check($sformatf("vec%0d_wdata", i), r_wdata, v.wdata);
      end else begin
        check($sformatf("vec%0d_no_req", i), 32'(r_reqs), 32'd0);
      end
    end

    // Timeout: no ack ever
    run_op(mk(1'b1, 1'b0, WIDTH_W, 1'b0, 32'h500, 32'h0), 32'h0, 0, 0);
    check("timeout_req_cycles", 32'(r_reqs), 32'(TO));
    check("timeout_stalls", 32'(r_stalls), 32'(TO + 1));
    check("timeout_fault", 32'(r_wb.accessFault), 32'd1);
    check("timeout_result", r_wb.result, 32'd0);
    check("timeout_req_dropped", 32'(dmem.dmemReq), 32'd0);

    // Flush in REQ: request held until ack, result discarded, next op normal
    run_op(mk(1'b1, 1'b0, WIDTH_W, 1'b0, 32'h400, 32'h0), 32'h11111111, 3, 1);
    check("flush_req_held", 32'(r_reqs), 32'd3);
    check("flush_wb_valid", 32'(r_wb.valid), 32'd0);
    run_op(mk(1'b1, 1'b0, WIDTH_W, 1'b0, 32'h404, 32'h0), 32'h22222222, 1, 0);
    check("after_flush_valid", 32'(r_wb.valid), 32'd1);
    check("after_flush_result", r_wb.result, 32'h22222222);
    check("after_flush_addr", r_addr, 32'h404);

    // Misaligned word load
    run_op(mk(1'b1, 1'b0, WIDTH_W, 1'b0, 32'h102, 32'h0), 32'hA5A55A5A, 1, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    check("misalign_no_req", 32'(r_reqs), 32'd0);
    check("misalign_flag", 32'(r_wb.misaligned), 32'd1);
    check("misalign_result", r_wb.result, 32'h102);
    check("misalign_stalls", 32'(r_stalls), 32'd1);
`else
    check("misalign_addr", r_addr, 32'h100);
    check("misalign_be", 32'(r_be), 32'hF);
    check("misalign_flag", 32'(r_wb.misaligned), 32'd0);
    check("misalign_result", r_wb.result, 32'hA5A55A5A);
`endif

    // Reset in the middle of an access
    ex = mk(1'b1, 1'b0, WIDTH_W, 1'b0, 32'h600, 32'h0);
    @(negedge clock);
    #1;
    check("midreset_req_before", 32'(dmem.dmemReq), 32'd1);
    reset = 1'b0;
    #1;
    check("midreset_req_dropped", 32'(dmem.dmemReq), 32'd0);
    check("midreset_stall", 32'(stall), 32'd0);
    check("midreset_wb_valid", 32'(wb_out.valid), 32'd0);
    ex = '0;
    @(negedge clock);
    reset = 1'b1;

    // Randomized ops against the model
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 8);
      p = mk(kind < 4, kind >= 4 && kind < 8, memoryWidth_'($urandom_range(0, 2)),
             1'($urandom_range(0, 1)), $urandom & 32'h0000_0FFF, $urandom);
      rd_word = $urandom;
      ack = $urandom_range(1, TO + 1);
      e = model(p, rd_word, ack);
      run_op(p, rd_word, ack, 0);
      check($sformatf("rnd%0d_stalls", n), 32'(r_stalls), 32'(e.stalls));
      check($sformatf("rnd%0d_reqs", n), 32'(r_reqs), 32'(e.reqs));
      check($sformatf("rnd%0d_result", n), r_wb.result, e.result);
      check($sformatf("rnd%0d_fwd", n), r_fwd, e.result);
      check($sformatf("rnd%0d_fault", n), 32'(r_wb.accessFault), 32'(e.fault));
      check($sformatf("rnd%0d_mis", n), 32'(r_wb.misaligned), 32'(e.mis));
      check($sformatf("rnd%0d_valid", n), 32'(r_wb.valid), 32'd1);
      if (e.issue) begin
        check($sformatf("rnd%0d_addr", n), r_addr, e.addr);
        check($sformatf("rnd%0d_be", n), 32'(r_be), 32'(e.be));
        check($sformatf("rnd%0d_we", n), 32'(r_we), 32'(e.we));
        check($sformatf("rnd%0d_wdata", n), r_wdata, e.wdata);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
